load_store_unit: RTL and testbench

//  Memory-side engine for load/store instructions: decodes opcode/funct3, drives a req/ack data-memory bus,

---
 rtl/load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-side engine for load/store instructions. Decodes opcode/funct3 of
// the instruction handed over from EX, runs one req/ack data-memory bus
// cycle, and aligns plus sign/zero-extends read data into ddt_o. The
// pipeline stalls on busy_o until the access completes, faults on a
// misaligned address, or is aborted by the bus timeout.
//
// Parameters
//   TIMEOUT      max cycles mem_req_o stays high without mem_ack_i (>=1)
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous reset, active-high
//   start_i      1-cycle request, sampled only while idle
//   inst_i       instruction: opcode = [6:0], funct3 = [14:12]
//   addr_i       effective byte address (ALU result)
//   wdata_in_i   store source (rs2), data in the low bits
//   busy_o       access in flight (pipeline stall)
//   done_o       1-cycle pulse, access completed successfully
//   ddt_o        aligned/extended load data, held until the next load
//   misalign_o   1-cycle pulse, misaligned access, no bus cycle issued
//   bus_err_o    1-cycle pulse, timeout expired, access aborted
//   mem_req_o    bus request, held until ack or timeout
//   mem_we_o     1 = store, 0 = load
//   mem_addr_o   word address {addr[31:2], 2'b00}
//   mem_wstrb_o  byte strobes for stores, zero otherwise
//   mem_wdata_o  store data replicated into its lane positions
//   mem_rdata_i  read word, sampled in the ack cycle
//   mem_ack_i    completion, ignored unless mem_req_o is high
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] ddt_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  // Counter only needs to hold 0 .. TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Selects and extends the addressed byte/half of a read word.
  function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] rd);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = rd >> {off, 3'b000};
    half    = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  load_align = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_align = {{16{half[15]}}, half};
      3'b010:  load_align = rd;
      3'b100:  load_align = {24'h000000, shifted[7:0]};
      3'b101:  load_align = {16'h0000, half};
      default: load_align = 32'h0000_0000;
    endcase
  endfunction

  // Byte strobes for a store of size f3[1:0] at byte offset off.
  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  // Replicates the store source so every lane carries it; strobes pick one.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      2'b10:   store_data = wd;
      default: store_data = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic             is_load_q, is_load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      ddt_q, ddt_d;

  logic [2:0]       funct3_s;
  logic             is_load_s;
  logic             is_store_s;
  logic             aligned_s;
  logic             unused_inst_s;

  assign funct3_s = inst_i[14:12];

  // Destination register and immediate bits are not needed here.
  assign unused_inst_s = ^{inst_i[31:15], inst_i[11:7]};

  // Decode: legal load/store opcode+funct3 and natural alignment of addr_i.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    aligned_s  = 1'b0;
    if (inst_i[6:0] == OP_LOAD) begin
      case (funct3_s)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load_s = 1'b1;
        default:                                is_load_s = 1'b0;
      endcase
    end else if (inst_i[6:0] == OP_STORE) begin
      case (funct3_s)
        3'b000, 3'b001, 3'b010: is_store_s = 1'b1;
        default:                is_store_s = 1'b0;
      endcase
    end else begin
      is_load_s  = 1'b0;
      is_store_s = 1'b0;
    end
    case (funct3_s[1:0])
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~addr_i[0];
      2'b10:   aligned_s = (addr_i[1:0] == 2'b00);
      default: aligned_s = 1'b0;
    endcase
  end

  // Next-state logic: FSM, timeout counter and all registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    ddt_d       = ddt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && (is_load_s || is_store_s)) begin
          funct3_d  = funct3_s;
          off_d     = addr_i[1:0];
          is_load_d = is_load_s;
          if (aligned_s) begin
            state_d     = ST_REQ;
            cnt_d       = {CNT_W{1'b0}};
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_s;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_wstrb_d = is_store_s ? store_strb(funct3_s, addr_i[1:0]) : 4'b0000;
            mem_wdata_d = is_store_s ? store_data(funct3_s, wdata_in_i) : 32'h0000_0000;
          end else begin
            // No bus cycle for a misaligned access.
            state_d    = ST_FAULT;
            misalign_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (mem_ack_i) begin
          state_d     = ST_RESP;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
          if (is_load_q) begin
            ddt_d = load_align(funct3_q, off_q, mem_rdata_i);
          end else begin
            ddt_d = ddt_q;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_FAULT;
          bus_err_d   = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_wstrb_d = 4'b0000;
        mem_wdata_d = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      is_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      ddt_q       <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      ddt_q       <= ddt_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign mem_wdata_o = mem_wdata_q;
  assign ddt_o       = ddt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit (TIMEOUT = 4). Each stimulus task sets
// the expected per-cycle outputs from the access rules (latency, alignment,
// extension, strobes); a single negedge process compares every output with
// those expectations. Literal checks pin the reference functions.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] inst_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_in_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] ddt_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .inst_i(inst_i),
    .addr_i(addr_i), .wdata_in_i(wdata_in_i), .busy_o(busy_o), .done_o(done_o),
    .ddt_o(ddt_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int req_cnt = 0;

  // Expected outputs for the current cycle
  logic        e_busy, e_done, e_mis, e_berr, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_ddt;
  logic [3:0]  e_strb;

  // Values captured in the first request cycle of an access
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    e_busy = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
    e_req = 1'b0; e_we = 1'b0; e_addr = 32'h0; e_strb = 4'h0; e_wdata = 32'h0;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    mk = {17'd0, f3, 5'd1, op};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
    h = (rd >> (16 * a[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  ref_load = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  ref_load = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b010:  ref_load = rd;
      3'b100:  ref_load = b;
      3'b101:  ref_load = h;
      default: ref_load = 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  ref_strb = 4'(1 << a[1:0]);
      3'b001:  ref_strb = a[1] ? 4'b1100 : 4'b0011;
      default: ref_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  ref_wdata = {4{wd[7:0]}};
      3'b001:  ref_wdata = {2{wd[15:0]}};
      default: ref_wdata = wd;
    endcase
  endfunction

  // Compare process: every output against the expectation, every cycle
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("done", 32'(done_o), 32'(e_done));
      chk("misalign", 32'(misalign_o), 32'(e_mis));
      chk("bus_err", 32'(bus_err_o), 32'(e_berr));
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("mem_wstrb", 32'(mem_wstrb_o), 32'(e_strb));
      chk("mem_wdata", mem_wdata_o, e_wdata);
      chk("ddt", ddt_o, e_ddt);
      if (e_req) begin
        chk("mem_we", 32'(mem_we_o), 32'(e_we));
        chk("mem_addr", mem_addr_o, e_addr);
      end
      if (mem_req_o) req_cnt++;
    end
  end

  // One access: ack_at = request cycle (1..TMO) raising ack, 0 = never.
  task automatic run_access(input logic [31:0] ins, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_at,
                            input logic [31:0] rd, output int done_cyc);
    logic [6:0] op;
    logic [2:0] f3;
    bit is_ld, is_st, aligned;
    op = ins[6:0];
    f3 = ins[14:12];
    is_ld = (op == 7'b0000011) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                                   f3 == 3'b100 || f3 == 3'b101);
    is_st = (op == 7'b0100011) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    aligned = (f3[1:0] == 2'b00) || (f3[1:0] == 2'b01 && a[0] == 1'b0) ||
              (f3[1:0] == 2'b10 && a[1:0] == 2'b00);
    done_cyc = -1;
    @(posedge clk_i); #1;
    start_i = 1'b1; inst_i = ins; addr_i = a; wdata_in_i = wd; mem_ack_i = 1'b0;
    set_idle();
    @(posedge clk_i); #1;
    start_i = 1'b0;
    set_idle();
    if (!(is_ld || is_st)) return;
    if (!aligned) begin
      e_mis = 1'b1;
      @(posedge clk_i); #1;
      set_idle();
      return;
    end
    for (int c = 1; c <= TMO; c++) begin
      set_idle();
      e_busy = 1'b1; e_req = 1'b1; e_we = is_st;
      e_addr = {a[31:2], 2'b00};
      e_strb = is_st ? ref_strb(f3, a) : 4'h0;
      e_wdata = is_st ? ref_wdata(f3, wd) : 32'h0;
      if (c == 1) begin
        cap_we = mem_we_o; cap_addr = mem_addr_o; cap_strb = mem_wstrb_o; cap_wdata = mem_wdata_o;
      end
      // A new start while busy must be ignored
      start_i = 1'b1;
      mem_ack_i = (c == ack_at);
      mem_rdata_i = (c == ack_at) ? rd : ~rd;
      @(posedge clk_i); #1;
      start_i = 1'b0; mem_ack_i = 1'b0;
      if (c == ack_at) begin
        set_idle();
        e_done = 1'b1;
        if (is_ld) e_ddt = ref_load(f3, a, rd);
        done_cyc = c + 1;
        @(posedge clk_i); #1;
        set_idle();
        return;
      end
    end
    set_idle();
    e_berr = 1'b1;
    @(posedge clk_i); #1;
    set_idle();
  endtask

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  initial begin
    int dc;
    rst_i = 1'b1; start_i = 1'b0; inst_i = 32'h0; addr_i = 32'h0; wdata_in_i = 32'h0;
    mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    set_idle();
    e_ddt = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_ddt", ddt_o, 32'h0);
    chk_en = 1'b1;

    // LW, ack in the fourth request cycle (ack meets timeout boundary)
    run_access(mk(LD, 3'b010), 32'h100, 32'h0, 4, 32'hDEADBEEF, dc);
    chk("lw_done_cycle", 32'(dc), 32'd5);
    chk("lw_ddt", ddt_o, 32'hDEADBEEF);
    chk("lw_mem_addr", cap_addr, 32'h100);
    chk("lw_wstrb", 32'(cap_strb), 32'h0);

    run_access(mk(LD, 3'b000), 32'h103, 32'h0, 1, 32'h80112233, dc);
    chk("lb_ddt", ddt_o, 32'hFFFFFF80);
    chk("lb_done_cycle", 32'(dc), 32'd2);
    run_access(mk(LD, 3'b100), 32'h103, 32'h0, 2, 32'h80112233, dc);
    chk("lbu_ddt", ddt_o, 32'h00000080);
    run_access(mk(LD, 3'b101), 32'h102, 32'h0, 1, 32'h80112233, dc);
    chk("lhu_ddt", ddt_o, 32'h00008011);
    run_access(mk(LD, 3'b001), 32'h102, 32'h0, 3, 32'h80112233, dc);
    chk("lh_ddt", ddt_o, 32'hFFFF8011);
    run_access(mk(LD, 3'b000), 32'h100, 32'h0, 1, 32'h80112233, dc);
    chk("lb0_ddt", ddt_o, 32'h00000033);

    // Stores; DDT must stay at the last load value
    run_access(mk(ST, 3'b000), 32'h201, 32'h000000A5, 2, 32'h0, dc);
    chk("sb_we", 32'(cap_we), 32'h1);
    chk("sb_addr", cap_addr, 32'h200);
    chk("sb_strb", 32'(cap_strb), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("sb_ddt_kept", ddt_o, 32'h00000033);
    run_access(mk(ST, 3'b001), 32'h202, 32'h1234ABCD, 1, 32'h0, dc);
    chk("sh_strb", 32'(cap_strb), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    run_access(mk(ST, 3'b010), 32'h204, 32'hCAFEF00D, 1, 32'h0, dc);
    chk("sw_strb", 32'(cap_strb), 32'hF);

    // Misaligned accesses
    req_cnt = 0;
    run_access(mk(LD, 3'b010), 32'h102, 32'h0, 1, 32'h0, dc);
    run_access(mk(LD, 3'b001), 32'h101, 32'h0, 1, 32'h0, dc);
    run_access(mk(ST, 3'b010), 32'h206, 32'h0, 1, 32'h0, dc);
    chk("misalign_no_req", 32'(req_cnt), 32'h0);
    chk("misalign_ddt_kept", ddt_o, 32'h00000033);

    // Ignored starts: non-memory opcode, reserved funct3
    run_access(mk(7'b0010011, 3'b000), 32'h100, 32'h0, 1, 32'h0, dc);
    run_access(mk(LD, 3'b011), 32'h100, 32'h0, 1, 32'h0, dc);
    run_access(mk(ST, 3'b100), 32'h100, 32'h0, 1, 32'h0, dc);
    chk("ignored_no_req", 32'(req_cnt), 32'h0);

    // Stray ack while idle
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    repeat (2) @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;

    // Timeout: no ack, then the next start is accepted
    req_cnt = 0;
    run_access(mk(LD, 3'b010), 32'h300, 32'h0, 0, 32'h0, dc);
    chk("tmo_req_cycles", 32'(req_cnt), 32'd4);
    chk("tmo_ddt_kept", ddt_o, 32'h00000033);
    run_access(mk(LD, 3'b010), 32'h300, 32'h0, 1, 32'h11223344, dc);
    chk("after_tmo_ddt", ddt_o, 32'h11223344);

    // Reset during a request, then a late ack
    @(posedge clk_i); #1;
    start_i = 1'b1; inst_i = mk(LD, 3'b010); addr_i = 32'h400;
    set_idle();
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      set_idle();
      e_busy = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h400;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    set_idle();
    e_ddt = 32'h0;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk("rstmid_mem_req", 32'(mem_req_o), 32'h0);
    chk("rstmid_done", 32'(done_o), 32'h0);
    chk("rstmid_ddt", ddt_o, 32'h0);
    chk("rstmid_mem_addr", mem_addr_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
